counter_updown_mod: RTL and testbench
=====================================

// Module: counter_updown_mod
// PURPOSE
//   Parametrised synchronous up/down counter with a programmable modulo limit.
//   Adds synchronous clear, parallel load, a clock-enable prescaler, and separate carry/borrow outputs.
//   General-purpose timebase/event counter for timers, PWM, and frame/line counters.
//   Multi-bit successor to the fixed 8-bit counter.
// PARAMETERS
//   WIDTH     8   counter width in bits (>=2)
//   PRESCALE  1   enabled cycles per count step (>=1); 1 = step on every enabled cycle
// PORTS
//   Clk    in   1      clock, rising edge
//   Reset  in   1      synchronous reset, active-high
//   E      in   1      count enable (1=count, 0=hold Q and prescaler)
//   M      in   1      direction (1=up, 0=down)
//   Clr    in   1      synchronous clear, active-high
//   Load   in   1      synchronous parallel load, active-high
//   D      in   WIDTH  load value
//   Limit  in   WIDTH  modulo limit; count range is 0..Limit inclusive
//   Q      out  WIDTH  counter value (registered)
//   Cout   out  1      carry: up step taken at the upper boundary
//   Bout   out  1      borrow: down step taken at Q==0
// BEHAVIOUR
//   - One clock (Clk). Reset is synchronous and active-high. All state updates on posedge Clk.
//   - Priority per edge: Reset > Clr > Load > count step.
//   - Reset=1: Q<=0 and prescaler<=0. Cout and Bout are forced to 0 while Reset=1.
//   - Clr=1: Q<=0 and prescaler<=0.
//   - Load=1: Q<=D and prescaler<=0. No step is taken in that cycle.
//     D>Limit is loaded unchanged.
//   - Prescaler: counts cycles with E=1; tick=1 when prescaler==PRESCALE-1, then prescaler wraps to 0.
//     PRESCALE=1: tick=1 on every cycle.
//     E=0: prescaler holds.
//   - step = E & tick & ~Reset & ~Clr & ~Load.
//   - Up step (M=1):
//     Q>=Limit: Q<=0 and Cout=1.
//     Otherwise: Q<=Q+1.
//   - Down step (M=0):
//     Q==0: Q<=Limit and Bout=1.
//     Otherwise: Q<=Q-1.
//   - Cout/Bout are combinational from registered Q, Limit, M and step. They are valid in the cycle
//     before the wrapping edge, and are single-cycle per step.
//   - Limit=0: Q stays at 0; every up step pulses Cout and every down step pulses Bout.
//   - A change to Limit takes effect at the next step. If Q>Limit, the next up step wraps to 0.
//   - Arithmetic is modulo 2^WIDTH. No comparison is wider than WIDTH.
//   - Latency: one cycle from a qualifying input to the Q update.
// CONFIGURATION
//   COUNTER_SATURATE_EN defined: saturating mode.
//     - Up step at Q>=Limit: Q<=Limit, Cout=1.
//     - Down step at Q==0: Q stays 0, Bout=1.
//     - Clr, Load and Reset are unchanged.
//   COUNTER_SATURATE_EN undefined: wrap mode as described in BEHAVIOUR.
// STRUCTURE
//   - Package counter_pkg:
//     - localparams DIR_UP=1'b1 and DIR_DOWN=1'b0;
//     - function clog2_min1(n), returning the prescaler width (minimum 1).
//   - Sub-module counter_prescaler: params PRESCALE; ports Clk, Reset, E, Clr (Clr or Load), tick.
//     Instantiated once. For PRESCALE=1 it reduces to tick=1.
//   - Top holds the Q register, the boundary compare, and the wrap/saturate mux.
// TESTING (WIDTH=8 unless noted)
//   1. Reset=1 for 2 cycles with E=1,M=1
//      -> Q=0x00, Cout=0, Bout=0. Reset and Load asserted together -> Q=0x00.
//   2. Limit=9, E=1, M=1 from Q=0, 10 clocks
//      -> Q goes 1..9, then 0. Cout=1 only in the cycle where Q=9.
//   3. Limit=0xFF, Q=0, E=1, M=0, one clock
//      -> Bout=1 before the edge, then Q=0xFF. Next clock -> Q=0xFE, Bout=0.
//   4. Load=1, D=0x7F, E=1, M=1 -> Q=0x7F, with no extra increment.
//      Clr=1 and Load=1 together -> Q=0x00.
//      Load D=0x20 with Limit=0x10, then one up step -> Q=0x00, Cout=1.
//   5. PRESCALE=4, E=1 for 12 cycles -> Q=3.
//      Drop E for 5 cycles -> Q and prescaler hold. Resume E -> next step after the remaining count.
//   6. COUNTER_SATURATE_EN, Limit=5, Q=5, up step -> Q=5, Cout=1.
//      Same stimulus without the macro -> Q=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package counter_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescaler counter width; never zero so a 1-bit register is still legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: asserts tick once every PRESCALE enabled cycles.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic E,
  input  logic Clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{Clk, Reset, E, Clr};
      assign tick      = 1'b1;
    end else begin : g_div
      localparam int PW = clog2_min1(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt_q, cnt_d;

      assign tick = (cnt_q == LAST);

      always_comb begin
        cnt_d = cnt_q;
        if (Clr)    cnt_d = '0;
        else if (E) cnt_d = tick ? '0 : cnt_q + PW'(1);
      end

      always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo-Limit counter with clear, load, prescaled enable, carry/borrow.
// Define COUNTER_SATURATE_EN to saturate at the boundaries instead of wrapping.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             E,
  input  logic             M,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Limit,
  output logic [WIDTH-1:0] Q,
  output logic             Cout,
  output logic             Bout
);

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WIDTH-1:0] q_q, q_d;
  logic             tick, step, at_top, at_zero;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .Clk   (Clk),
    .Reset (Reset),
    .E     (E),
    .Clr   (Clr | Load),
    .tick  (tick)
  );

  // at_top uses >= so a Q left above a lowered Limit still wraps on the next up step.
  assign at_top  = (q_q >= Limit);
  assign at_zero = (q_q == '0);
  assign step    = E & tick & ~Reset & ~Clr & ~Load;
  assign Cout    = step & (M == DIR_UP)   & at_top;
  assign Bout    = step & (M == DIR_DOWN) & at_zero;

  always_comb begin
    q_d = q_q;
    if (Clr)
      q_d = '0;
    else if (Load)
      q_d = D;
    else if (step) begin
      if (M == DIR_UP)
        q_d = at_top  ? (SAT ? Limit : '0) : q_q + WIDTH'(1);
      else
        q_d = at_zero ? (SAT ? '0 : Limit) : q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod (PRESCALE=1 and PRESCALE=4 instances).
module tb_counter_updown_mod;

  logic       Clk = 1'b0;
  logic       Reset, E, M, Clr, Load;
  logic [7:0] D, Limit;
  logic [7:0] Q, Q4;
  logic       Cout, Bout, Cout4, Bout4;

  typedef struct {
    logic [7:0] q;
    logic       c;
    logic       b;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;
  int   tests = 0;
  int   fails = 0;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 Clk = ~Clk;

  counter_updown_mod #(.WIDTH(8), .PRESCALE(1)) dut (
    .Clk(Clk), .Reset(Reset), .E(E), .M(M), .Clr(Clr), .Load(Load),
    .D(D), .Limit(Limit), .Q(Q), .Cout(Cout), .Bout(Bout)
  );

  counter_updown_mod #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .E(E), .M(M), .Clr(Clr), .Load(Load),
    .D(D), .Limit(Limit), .Q(Q4), .Cout(Cout4), .Bout(Bout4)
  );

  task automatic drive(input logic rst, input logic e, input logic m, input logic clr,
                       input logic ld, input logic [7:0] d, input logic [7:0] lim);
    Reset = rst; E = e; M = m; Clr = clr; Load = ld; D = d; Limit = lim;
  endtask

  // Runs the queued cycles against the PRESCALE=1 instance.
  task automatic run_main(input string name);
    int n;
    n = 0;
    while (sbq.size() > 0) begin
      #2;
      ex = sbq[0];
      tests++;
      if (Cout !== ex.c || Bout !== ex.b) begin
        fails++;
        $display("FAIL %s[%0d] flags: got Cout=%b Bout=%b, want Cout=%b Bout=%b",
                 name, n, Cout, Bout, ex.c, ex.b);
      end
      @(posedge Clk); #1;
      ex = sbq.pop_front();
      tests++;
      if (Q !== ex.q) begin
        fails++;
        $display("FAIL %s[%0d] Q: got %h, want %h", name, n, Q, ex.q);
      end
      n++;
    end
  endtask

  // Single cycle: drive inputs, queue the expectation, then check it.
  task automatic cyc(input string name, input logic rst, input logic e, input logic m,
                     input logic clr, input logic ld, input logic [7:0] d,
                     input logic [7:0] lim, input logic [7:0] eq, input logic ec,
                     input logic eb);
    drive(rst, e, m, clr, ld, d, lim);
    sbq.push_back('{q: eq, c: ec, b: eb});
    run_main(name);
  endtask

  task automatic test_reset();
    cyc("reset0", 1, 1, 1, 0, 0, 8'h00, 8'h09, 8'h00, 0, 0);
    cyc("reset1", 1, 1, 1, 0, 0, 8'h00, 8'h09, 8'h00, 0, 0);
    cyc("reset_load", 1, 1, 1, 0, 1, 8'h55, 8'h09, 8'h00, 0, 0);
  endtask

  task automatic test_up_mod();
    cyc("up_clr", 0, 1, 1, 1, 0, 8'h00, 8'h09, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 0, 0, 8'h00, 8'h09);
      sbq.push_back('{q: (i == 9) ? 8'h00 : 8'(i + 1), c: (i == 9), b: 1'b0});
      run_main("up_mod");
    end
  endtask

  task automatic test_down_wrap();
    cyc("dn_clr", 0, 1, 0, 1, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
    cyc("dn_wrap", 0, 1, 0, 0, 0, 8'h00, 8'hFF, 8'hFF, 0, 1);
    cyc("dn_next", 0, 1, 0, 0, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
    cyc("dn_hold", 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
  endtask

  task automatic test_load();
    cyc("load_7f", 0, 1, 1, 0, 1, 8'h7F, 8'hFF, 8'h7F, 0, 0);
    cyc("load_inc", 0, 1, 1, 0, 0, 8'h00, 8'hFF, 8'h80, 0, 0);
    cyc("clr_load", 0, 1, 1, 1, 1, 8'h7F, 8'hFF, 8'h00, 0, 0);
    cyc("load_over", 0, 1, 1, 0, 1, 8'h20, 8'h10, 8'h20, 0, 0);
    cyc("over_up", 0, 1, 1, 0, 0, 8'h00, 8'h10, SAT ? 8'h10 : 8'h00, 1, 0);
    cyc("lim0_clr", 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    cyc("lim0_up", 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0);
    cyc("lim0_dn", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1);
  endtask

  task automatic test_saturate();
    cyc("sat_load", 0, 1, 1, 0, 1, 8'h05, 8'h05, 8'h05, 0, 0);
    cyc("sat_up", 0, 1, 1, 0, 0, 8'h00, 8'h05, SAT ? 8'h05 : 8'h00, 1, 0);
    cyc("sat_clr", 0, 1, 0, 1, 0, 8'h00, 8'h05, 8'h00, 0, 0);
    cyc("sat_dn", 0, 1, 0, 0, 0, 8'h00, 8'h05, SAT ? 8'h00 : 8'h05, 0, 1);
  endtask

  // Checks the PRESCALE=4 instance: schedule is built as {E, expected Q} per cycle.
  task automatic test_prescale();
    logic e_seq[$];
    int   nq;
    drive(0, 1, 1, 1, 0, 8'h00, 8'hFF);
    @(posedge Clk); #1;
    tests++;
    if (Q4 !== 8'h00) begin
      fails++;
      $display("FAIL presc_clr Q: got %h, want 00", Q4);
    end
    nq = 0;
    for (int i = 0; i < 14; i++) e_seq.push_back(1'b1);
    for (int i = 0; i < 5; i++)  e_seq.push_back(1'b0);
    for (int i = 0; i < 2; i++)  e_seq.push_back(1'b1);
    // steps land on enabled cycles 4, 8, 12 and 16 (the 16th resumes after the E gap)
    for (int i = 0; i < e_seq.size(); i++) begin
      if (i == 3 || i == 7 || i == 11 || i == 20) nq++;
      sbq.push_back('{q: 8'(nq), c: 1'b0, b: 1'b0});
    end
    for (int i = 0; i < e_seq.size(); i++) begin
      drive(0, e_seq[i], 1, 0, 0, 8'h00, 8'hFF);
      @(posedge Clk); #1;
      ex = sbq.pop_front();
      tests++;
      if (Q4 !== ex.q || Cout4 !== 1'b0) begin
        fails++;
        $display("FAIL presc[%0d]: got Q=%h Cout=%b, want Q=%h Cout=0", i, Q4, Cout4, ex.q);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc("b2b_load", 0, 1, 1, 0, 1, 8'h03, 8'h09, 8'h03, 0, 0);
    cyc("b2b_up", 0, 1, 1, 0, 0, 8'h00, 8'h09, 8'h04, 0, 0);
    cyc("b2b_dn", 0, 1, 0, 0, 0, 8'h00, 8'h09, 8'h03, 0, 0);
    cyc("b2b_up2", 0, 1, 1, 0, 0, 8'h00, 8'h09, 8'h04, 0, 0);
    cyc("b2b_lim", 0, 1, 1, 0, 0, 8'h00, 8'h04, SAT ? 8'h04 : 8'h00, 1, 0);
  endtask

  initial begin
    drive(1, 1, 1, 0, 0, 8'h00, 8'h09);
    #1;
    test_reset();
    test_up_mod();
    test_down_wrap();
    test_load();
    test_saturate();
    test_back_to_back();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
